// File: rtl/motor_pkg.sv
// Shared types and constants for the move sequencer slice.
package motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SEEK,
    ST_SETTLE,
    ST_FAULT
  } state_t;

  localparam logic TGT_90  = 1'b1;
  localparam logic TGT_180 = 1'b0;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned ERR_W  = 12;

  // Clamp the error magnitude into [lo, hi] at full error width, then keep
  // the low duty bits (hi always fits in DUTY_W).
  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [ERR_W-1:0] e,
    input logic [ERR_W-1:0] lo,
    input logic [ERR_W-1:0] hi
  );
    logic [ERR_W-1:0] c;
    c = e;
    if (e < lo)
      c = lo;
    else if (e > hi)
      c = hi;
    return c[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/motor_move_seq_if.sv
// Host command handshake between the command source and the sequencer.
interface motor_move_seq_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_target;

  modport master (output cmd_valid, output cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, output cmd_ready);
endinterface

// File: rtl/motor_pwm_gen.sv
// Free-running 8-bit PWM with duty reloaded only at the 255->0 wrap.
module motor_pwm_gen
  import motor_pkg::*;
(
  input  logic              clk_48,
  input  logic              reset_n,
  input  logic [DUTY_W-1:0] duty,
  input  logic              force_off,
  output logic              pwm
);

  logic [DUTY_W-1:0] cnt_q;
  logic [DUTY_W-1:0] duty_q;

  // Counter, wrap-synchronous duty load, and registered compare output.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (force_off)
        duty_q <= '0;
      else if (cnt_q == '1)
        duty_q <= duty;
      pwm <= !force_off && (cnt_q < duty_q);
    end
  end

endmodule

// File: rtl/motor_move_seq.sv
// Move sequencer: command accept, pipeline prime, seek/settle control,
// timeout fault, and PWM/direction drive from the returned position error.
module motor_move_seq
  import motor_pkg::*;
#(
  parameter int unsigned TOL         = 2,
  parameter int unsigned SETTLE_CYC  = 48000,
  parameter int unsigned TIMEOUT_CYC = 48000000,
  parameter int unsigned DUTY_MIN    = 40,
  parameter int unsigned DUTY_MAX    = 230
)(
  input  logic             clk_48,
  input  logic             reset_n,
  motor_move_seq_if.slave  cmd,
  input  logic             abort,
  input  logic [ERR_W-1:0] errorabs,
  input  logic             errorsign,
  output logic             target_sel,
  output logic             motor_pwm,
  output logic             motor_dir,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state_q, state_d;
  logic              prime_q;
  logic [SET_W-1:0]  scnt_q;
  logic [TMO_W-1:0]  tcnt_q;
  logic              cmd_ready_q;
  logic              accept, done_d, drive, in_tol, tmo, settled, force_off;
  logic [DUTY_W-1:0] duty_cmd;

  assign cmd.cmd_ready = cmd_ready_q;
  assign in_tol  = (errorabs <= ERR_W'(TOL));
  assign tmo     = (tcnt_q == TMO_W'(TIMEOUT_CYC - 1));
  assign settled = (scnt_q == SET_W'(SETTLE_CYC - 1));

  // Next-state decode; abort is applied last so it overrides every other
  // outcome, then timeout beats settle-complete beats tolerance change.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    drive   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid && cmd_ready_q) begin
          accept  = 1'b1;
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (prime_q)
          state_d = ST_SEEK;
      end
      ST_SEEK: begin
        if (tmo)
          state_d = ST_FAULT;
        else if (in_tol)
          state_d = ST_SETTLE;
        else
          drive = 1'b1;
      end
      ST_SETTLE: begin
        if (tmo)
          state_d = ST_FAULT;
        else if (settled) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (!in_tol)
          state_d = ST_SEEK;
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      drive   = 1'b0;
    end
  end

  assign force_off = (state_d != ST_SEEK);
  assign duty_cmd  = drive ? clamp_duty(errorabs, ERR_W'(DUTY_MIN), ERR_W'(DUTY_MAX)) : '0;

  // State register plus prime, settle and timeout counters.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      prime_q <= 1'b0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prime_q <= (state_q == ST_PRIME) && !prime_q;
      scnt_q  <= (state_q == ST_SETTLE) ? scnt_q + 1'b1 : '0;
      if (state_q == ST_PRIME)
        tcnt_q <= '0;
      else if ((state_q == ST_SEEK || state_q == ST_SETTLE) && !tmo)
        tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // Registered outputs, all derived from the decided next state.
  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      target_sel  <= 1'b0;
      motor_dir   <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == ST_IDLE);
      busy        <= (state_d != ST_IDLE);
      done        <= done_d;
      if (accept) begin
        fault      <= 1'b0;
        target_sel <= cmd.cmd_target ? TGT_90 : TGT_180;
      end else if (state_d == ST_FAULT)
        fault <= 1'b1;
      if (drive)
        motor_dir <= errorsign;
    end
  end

  motor_pwm_gen u_pwm (
    .clk_48    (clk_48),
    .reset_n   (reset_n),
    .duty      (duty_cmd),
    .force_off (force_off),
    .pwm       (motor_pwm)
  );

endmodule
